countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//  Control stage directly upstream of the four chained BCD down-counter digits (MM:SS timer).
//  - Conditions the raw start/pause and clear buttons.
//  - Divides clk down to a count tick and issues one-cycle decrease pulses to the seconds-ones digit.
//  - Runs the IDLE/RUN/PAUSE/DONE state machine and raises the alarm when the count reaches 00:00.
//  - Drives load_n to reload the digits with their initial values.
// PARAMETERS
//  TICK_DIV      100_000_000  clk cycles per count tick (>=2)
//  DEBOUNCE_CYC  16           cycles a synchronized button level must be stable before it is accepted (>=1)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  btn_start    in   1   raw start/pause button, active-high, asynchronous to clk
//  btn_clear    in   1   raw clear button, active-high, asynchronous to clk
//  digit_value  in   16  current digit values {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
//  decrease     out  1   one-cycle pulse to the sec_ones digit decrease input
//  load_n       out  1   active-low one-cycle reload; the system ANDs it with rst_n for the digits' rst_n
//  state        out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//  running      out  1   1 while state==RUN
//  alarm        out  1   1 while state==DONE
// BEHAVIOUR
//  Reset values: state=IDLE, decrease=0, load_n=1, running=0, alarm=0; divider=0; debounce/sync regs=0.
//  Button conditioning (each button independently):
//  - 2-FF synchronizer, then a debounce counter.
//  - The accepted level changes only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles.
//  - Each accepted 0->1 edge yields a one-cycle pulse (start_p / clear_p).
//  - Latency from a stable raw edge to the pulse: 2 + DEBOUNCE_CYC + 1 cycles.
//  Divider:
//  - In RUN, counts 0..TICK_DIV-1 and wraps to 0; tick=1 in the cycle where divider==TICK_DIV-1.
//  - In PAUSE, holds its value, so a resumed tick arrives after the remaining cycles.
//  - In IDLE and DONE, forced to 0.
//  all_zero = (digit_value==16'h0000), evaluated combinationally every cycle.
//  decrease (registered, 1 cycle after the qualifying tick) = RUN & tick & ~all_zero & ~start_p & ~clear_p.
//  - A tick coinciding with a button pulse is discarded.
//  - decrease is never issued at 00:00, so the digits cannot wrap to 59:59.
//  FSM transitions; priority: clear_p > start_p > all_zero.
//  - any state, clear_p: -> IDLE; load_n=0 for exactly the next cycle.
//  - IDLE, start_p: -> DONE if all_zero, else -> RUN.
//  - RUN, start_p: -> PAUSE.
//  - RUN, all_zero: -> DONE. This is the cycle after the last decrease takes effect in the digits.
//  - PAUSE, start_p: -> RUN (divider resumes from its held value).
//  - DONE, start_p: -> IDLE; load_n=0 for exactly the next cycle.
//  running, alarm and state are registered and decode the current state.
//  load_n is never low for more than one cycle; back-to-back reload requests yield consecutive low cycles.
//  Asserting rst_n mid-operation returns every output to its reset value immediately.
//  - Any partially accepted button edge is lost.
// TESTING  (TICK_DIV=4, DEBOUNCE_CYC=2)
//  1 Reset pulse with buttons low -> state=00, decrease=0, load_n=1, alarm=0, running=0 on release.
//  2 digit_value=16'h0003; press start; model digits decrement -> exactly 3 decrease pulses 4 cycles apart;
//    after 0000, state=11 and alarm=1; no 4th pulse.
//  3 digit_value=16'h0100; press start, then press again 2 cycles after a decrease -> PAUSE, no decrease for 20 cycles;
//    press start -> next decrease exactly 2 cycles after state returns to 01.
//  4 In RUN, clear_p in the same cycle as tick -> no decrease, state=00 next cycle, load_n low exactly 1 cycle.
//  5 digit_value=0, press start in IDLE -> state goes 00->11 directly, alarm=1, no decrease;
//    press start -> state=00, load_n low 1 cycle.
//  6 btn_start glitches high for 1 cycle, three times, 3 cycles apart -> no start pulse, state stays 00;
//    a level held 6 cycles produces exactly one pulse.

Source files
------------

// File: rtl/countdown_if.sv
// Signal bundle between the MM:SS timer control stage and the surrounding buttons/digit chain.
interface countdown_if;
  logic        btn_start;
  logic        btn_clear;
  logic [15:0] digit_value;
  logic        decrease;
  logic        load_n;
  logic [1:0]  state;
  logic        running;
  logic        alarm;

  modport master (
    output btn_start, btn_clear, digit_value,
    input  decrease, load_n, state, running, alarm
  );

  modport slave (
    input  btn_start, btn_clear, digit_value,
    output decrease, load_n, state, running, alarm
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Control stage of a four-digit MM:SS BCD countdown: button conditioning, count-tick divider,
// IDLE/RUN/PAUSE/DONE sequencing, decrease pulses to the seconds-ones digit and digit reload.
module countdown_ctrl #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  countdown_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  // Bit 0 is the start/pause button, bit 1 the clear button.
  logic [1:0]       btn_raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       acc_r;
  logic [1:0]       acc_d_r;
  logic [1:0]       pulse_r;
  logic [DB_W-1:0]  db_cnt_r [2];

  logic             start_p_s;
  logic             clear_p_s;
  logic             all_zero_s;
  logic             tick_s;
  logic             reload_s;
  logic             dec_nx_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nx_s;
  logic             dec_r;
  logic             load_n_r;
  logic             running_r;
  logic             alarm_r;

  assign btn_raw_s  = {bus.btn_clear, bus.btn_start};
  assign start_p_s  = pulse_r[0];
  assign clear_p_s  = pulse_r[1];
  assign all_zero_s = (bus.digit_value == 16'h0000);
  assign tick_s     = (state_r == ST_RUN) && (div_r == DIV_LAST);

  // Two-flop synchronizer, stability counter and accepted-rise pulse for each button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= 2'b00;
      sync2_r     <= 2'b00;
      acc_r       <= 2'b00;
      acc_d_r     <= 2'b00;
      pulse_r     <= 2'b00;
      db_cnt_r[0] <= {DB_W{1'b0}};
      db_cnt_r[1] <= {DB_W{1'b0}};
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      acc_d_r <= acc_r;
      pulse_r <= acc_r & ~acc_d_r;
      for (int i = 0; i < 2; i++) begin
        // The counter only advances while the synchronized level disagrees with the accepted one.
        if (sync2_r[i] == acc_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          acc_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Next state, reload request, divider step and qualified decrease
  always_comb begin
    state_nx_s = state_r;
    reload_s   = 1'b0;
    div_nx_s   = {DIV_W{1'b0}};
    dec_nx_s   = 1'b0;

    if (clear_p_s) begin
      state_nx_s = ST_IDLE;
      reload_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_p_s) state_nx_s = all_zero_s ? ST_DONE : ST_RUN;
          else           state_nx_s = ST_IDLE;
        end
        ST_RUN: begin
          if (start_p_s)       state_nx_s = ST_PAUSE;
          else if (all_zero_s) state_nx_s = ST_DONE;
          else                 state_nx_s = ST_RUN;
        end
        ST_PAUSE: begin
          if (start_p_s) state_nx_s = ST_RUN;
          else           state_nx_s = ST_PAUSE;
        end
        ST_DONE: begin
          if (start_p_s) begin
            state_nx_s = ST_IDLE;
            reload_s   = 1'b1;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end

    // PAUSE keeps the partial tick period so a resume finishes the interrupted second.
    case (state_r)
      ST_RUN:   div_nx_s = tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
      ST_PAUSE: div_nx_s = div_r;
      default:  div_nx_s = {DIV_W{1'b0}};
    endcase

    dec_nx_s = tick_s & ~all_zero_s & ~start_p_s & ~clear_p_s;
  end

  // State, divider and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      div_r     <= {DIV_W{1'b0}};
      dec_r     <= 1'b0;
      load_n_r  <= 1'b1;
      running_r <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      div_r     <= div_nx_s;
      dec_r     <= dec_nx_s;
      load_n_r  <= ~reload_s;
      running_r <= (state_nx_s == ST_RUN);
      alarm_r   <= (state_nx_s == ST_DONE);
    end
  end

  assign bus.decrease = dec_r;
  assign bus.load_n   = load_n_r;
  assign bus.state    = state_r;
  assign bus.running  = running_r;
  assign bus.alarm    = alarm_r;
endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed timer scenarios and randomized button traffic, compared
// cycle by cycle with a behavioural model that also plays the role of the BCD digit chain.
module tb_countdown_ctrl;
  localparam int TD = 4;
  localparam int DB = 2;
  localparam logic [5:0] RST_V = 6'b00_0_1_0_0;

  logic clk;
  logic rst_n;
  countdown_if bus ();

  countdown_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state numbers 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; [0] = start button, [1] = clear button
  int m_state, m_div, m_dec, m_load_n;
  int m_s1 [2];
  int m_s2 [2];
  int m_acc [2];
  int m_run [2];
  int m_rose [2];
  int m_pulse [2];
  int raw [2];
  int sp, cp, az, tk;
  logic [15:0] digits_q;
  logic [15:0] init_val;

  wire [5:0] got_v = {bus.state, bus.decrease, bus.load_n, bus.running, bus.alarm};
  wire [5:0] exp_v = {m_state[1:0], m_dec[0], m_load_n[0], (m_state == 1), (m_state == 3)};

  function automatic logic [15:0] to_bcd(input int t);
    return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
  endfunction

  function automatic int to_sec(input logic [15:0] d);
    return 600 * int'(d[15:12]) + 60 * int'(d[11:8]) + 10 * int'(d[7:4]) + int'(d[3:0]);
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state  = 0;
      m_div    = 0;
      m_dec    = 0;
      m_load_n = 1;
      digits_q = init_val;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_run[b] = 0; m_rose[b] = 0; m_pulse[b] = 0;
      end
    end else begin
      raw[0] = int'(bus.btn_start);
      raw[1] = int'(bus.btn_clear);
      sp = m_pulse[0];
      cp = m_pulse[1];
      az = (bus.digit_value == 16'h0000) ? 1 : 0;
      tk = (m_state == 1 && m_div == TD - 1) ? 1 : 0;
      // The digit chain counts down on the edge that ends a decrease cycle.
      if (m_dec != 0) digits_q = (to_sec(digits_q) == 0) ? to_bcd(3599) : to_bcd(to_sec(digits_q) - 1);
      m_dec    = (tk != 0 && az == 0 && sp == 0 && cp == 0) ? 1 : 0;
      m_load_n = (cp != 0 || (m_state == 3 && sp != 0)) ? 0 : 1;
      if (m_state == 1)      m_div = (tk != 0) ? 0 : m_div + 1;
      else if (m_state != 2) m_div = 0;
      if (cp != 0)                          m_state = 0;
      else if (sp != 0 && m_state == 0)     m_state = (az != 0) ? 3 : 1;
      else if (sp != 0 && m_state == 1)     m_state = 2;
      else if (sp != 0 && m_state == 2)     m_state = 1;
      else if (sp != 0 && m_state == 3)     m_state = 0;
      else if (m_state == 1 && az != 0)     m_state = 3;
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = m_rose[b];
        m_rose[b]  = 0;
        if (m_s2[b] != m_acc[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DB) begin
            m_acc[b]  = m_s2[b];
            m_run[b]  = 0;
            m_rose[b] = m_acc[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      // load_n low clears the digits asynchronously back to their initial value.
      if (m_load_n == 0) digits_q = init_val;
    end
  end

  always begin
    @(negedge clk);
    bus.digit_value = digits_q;
  end

  task automatic do_reset(input logic [15:0] init);
    init_val      = init;
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    init_val      = 16'h0003;
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (got_v !== RST_V) begin n_bad++; $display("FAIL reset_active got=%b want=%b", got_v, RST_V); end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (got_v !== RST_V) begin n_bad++; $display("FAIL reset_release c=%0d got=%b want=%b", c, got_v, RST_V); end
    end
  endtask

  task automatic test_countdown();
    int dec_cyc [$];
    do_reset(16'h0003);
    for (int c = 0; c < 40; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL countdown_lockstep c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (bus.decrease === 1'b1) dec_cyc.push_back(c);
    end
    n_cmp++;
    if (dec_cyc.size() != 3) begin
      n_bad++; $display("FAIL countdown_pulses got=%0d want=3", dec_cyc.size());
    end else if (dec_cyc[1] - dec_cyc[0] != 4 || dec_cyc[2] - dec_cyc[1] != 4) begin
      n_bad++; $display("FAIL countdown_spacing got=%0d,%0d want=4,4", dec_cyc[1] - dec_cyc[0], dec_cyc[2] - dec_cyc[1]);
    end
    n_cmp++;
    if ({bus.state, bus.alarm, bus.running} !== 4'b1110) begin
      n_bad++; $display("FAIL countdown_done got st=%b al=%b run=%b want st=11 al=1 run=0", bus.state, bus.alarm, bus.running);
    end
  endtask

  task automatic test_pause();
    int found, bad_cnt, q, d;
    do_reset(16'h0100);
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL pause_lockstep_a c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (m_dec != 0) found = 1;
    end
    n_cmp++;
    if (found == 0) begin n_bad++; $display("FAIL pause_first_dec got=none want=decrease within 40 cycles"); end
    for (int c = 0; c < 12; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL pause_lockstep_b c=%0d got=%b want=%b", c, got_v, exp_v); end
    end
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.decrease !== 1'b0 || bus.state !== 2'b10) bad_cnt++;
    end
    n_cmp++;
    if (bad_cnt != 0) begin n_bad++; $display("FAIL pause_hold got=%0d bad cycles want=0", bad_cnt); end
    q = -1;
    d = -1;
    for (int c = 0; c < 30; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL pause_lockstep_c c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (q < 0 && bus.state === 2'b01) q = c;
      if (q >= 0 && d < 0 && bus.decrease === 1'b1) d = c;
    end
    n_cmp++;
    if (q < 0 || d < 0 || d - q != 2) begin
      n_bad++; $display("FAIL pause_resume_gap got=%0d (run at %0d, dec at %0d) want=2", d - q, q, d);
    end
  endtask

  task automatic test_clear_tick();
    int found;
    do_reset(16'h0030);
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL clear_lockstep_a c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (m_dec != 0) found = 1;
    end
    n_cmp++;
    if (found == 0) begin n_bad++; $display("FAIL clear_first_dec got=none want=decrease within 40 cycles"); end
    // Two cycles on, a clear press lands its pulse exactly on a tick cycle.
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      bus.btn_clear = (k <= 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL clear_lockstep_b k=%0d got=%b want=%b", k, got_v, exp_v); end
      if (k == 6) begin
        n_cmp++;
        if ({bus.state, bus.decrease, bus.load_n} !== 4'b0000) begin
          n_bad++; $display("FAIL clear_on_tick got st=%b dec=%b ld=%b want st=00 dec=0 ld=0", bus.state, bus.decrease, bus.load_n);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (bus.load_n !== 1'b1) begin n_bad++; $display("FAIL clear_load_width got ld=%b want=1", bus.load_n); end
      end
    end
  endtask

  task automatic test_zero_start();
    int saw_run, saw_dec, low_cnt;
    do_reset(16'h0000);
    saw_run = 0;
    saw_dec = 0;
    for (int c = 0; c < 15; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL zero_lockstep_a c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (bus.state === 2'b01) saw_run++;
      if (bus.decrease === 1'b1) saw_dec++;
    end
    n_cmp++;
    if (saw_run != 0 || saw_dec != 0 || {bus.state, bus.alarm} !== 3'b111) begin
      n_bad++; $display("FAIL zero_direct_done got run=%0d dec=%0d st=%b al=%b want 0 0 11 1", saw_run, saw_dec, bus.state, bus.alarm);
    end
    low_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL zero_lockstep_b c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (bus.load_n === 1'b0) low_cnt++;
    end
    n_cmp++;
    if (low_cnt != 1 || bus.state !== 2'b00) begin
      n_bad++; $display("FAIL zero_restart got low=%0d st=%b want low=1 st=00", low_cnt, bus.state);
    end
  endtask

  task automatic test_glitch();
    int bad_cnt, rises, paused;
    logic [1:0] prev;
    do_reset(16'h0500);
    bad_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      bus.btn_start = (c == 0 || c == 4 || c == 8);
      @(negedge clk);
      if (bus.state !== 2'b00) bad_cnt++;
    end
    n_cmp++;
    if (bad_cnt != 0) begin n_bad++; $display("FAIL glitch_reject got=%0d non-idle cycles want=0", bad_cnt); end
    rises  = 0;
    paused = 0;
    prev   = bus.state;
    for (int c = 0; c < 30; c++) begin
      bus.btn_start = (c < 6);
      @(negedge clk);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL glitch_lockstep c=%0d got=%b want=%b", c, got_v, exp_v); end
      if (bus.state === 2'b01 && prev !== 2'b01) rises++;
      if (bus.state === 2'b10) paused++;
      prev = bus.state;
    end
    n_cmp++;
    if (rises != 1 || paused != 0 || bus.state !== 2'b01) begin
      n_bad++; $display("FAIL glitch_single_press got starts=%0d pauses=%0d st=%b want 1 0 01", rises, paused, bus.state);
    end
  endtask

  task automatic test_random();
    int hs, hc, rst_at;
    for (int it = 0; it < 4; it++) begin
      do_reset(to_bcd(int'($urandom_range(0, 40))));
      hs     = 0;
      hc     = 0;
      rst_at = int'($urandom_range(100, 250));
      for (int c = 0; c < 300; c++) begin
        if (hs == 0) begin bus.btn_start = ($urandom_range(0, 2) == 0); hs = int'($urandom_range(1, 9)); end
        else hs--;
        if (hc == 0) begin bus.btn_clear = ($urandom_range(0, 7) == 0); hc = int'($urandom_range(1, 9)); end
        else hc--;
        if (c == rst_at) begin
          #2;
          rst_n = 1'b0;
          #1;
          n_cmp++;
          if (got_v !== RST_V) begin n_bad++; $display("FAIL random_midreset it=%0d got=%b want=%b", it, got_v, RST_V); end
        end
        @(negedge clk);
        n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL random_lockstep it=%0d c=%0d got=%b want=%b", it, c, got_v, exp_v); end
        if (c == rst_at) rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.btn_start   = 1'b0;
    bus.btn_clear   = 1'b0;
    init_val        = 16'h0000;
    digits_q        = 16'h0000;
    test_reset();
    test_countdown();
    test_pause();
    test_clear_tick();
    test_zero_start();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
